// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: opcode fields, fetch constants and the fetch
// entry / state types used by the IF stage.
package legv8_pkg;

  // R/D-format opcodes occupy instr[31:21]; CB-format instr[31:24]; B-format instr[31:26].
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [7:0]  OP_CBZ  = 8'hB4;
  localparam logic [7:0]  OP_CBNZ = 8'hB5;
  localparam logic [5:0]  OP_B    = 6'h05;

  localparam logic [63:0] INSTR_BYTES      = 64'd4;
  localparam logic [31:0] NOP_INSTR        = 32'h0;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } fetch_entry_t;

  typedef enum logic {
    RUN  = 1'b0,
    HELD = 1'b1
  } fetch_state_e;

  function automatic logic [63:0] align_pc(input logic [63:0] addr);
    return addr & ~64'h3;
  endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry skid buffer for an instruction that returns while decode is stalled.
// Priority: clear > load > drain.
module fetch_hold_buffer
  import legv8_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         drain,
  input  logic         clear,
  input  fetch_entry_t entry_in,
  output fetch_entry_t entry_out,
  output logic         full
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry_out <= '0;
      full      <= 1'b0;
    end else if (clear) begin
      full      <= 1'b0;
    end else if (load) begin
      entry_out <= entry_in;
      full      <= 1'b1;
    end else if (drain) begin
      full      <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// LEGv8 fetch stage: PC, synchronous imem request, stall skid buffer and
// IF/ID register with branch redirect/flush.
module instruction_fetch
  import legv8_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [63:0] pc_out,
  output logic        valid_out
);

  logic [63:0]  pc;
  logic         inflight;
  logic [63:0]  inflight_pc;
  fetch_state_e state;
  fetch_entry_t resp;
  fetch_entry_t hold_q;
  logic         hold_full;
  logic         hold_load;
  logic         hold_drain;

  assign imem_req  = reset_n & ~stall & ~branch_taken;
  assign imem_addr = pc;
  assign resp      = '{instr: imem_rdata, pc: inflight_pc};

  // A response arriving under stall is parked; the parked word leaves on release.
  assign hold_load  = stall & ~branch_taken & inflight;
  assign hold_drain = ~stall & ~branch_taken & hold_full;

  fetch_hold_buffer u_hold (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (hold_load),
    .drain     (hold_drain),
    .clear     (branch_taken),
    .entry_in  (resp),
    .entry_out (hold_q),
    .full      (hold_full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      instruction <= NOP_INSTR;
      pc_out      <= '0;
      valid_out   <= 1'b0;
      state       <= RUN;
    end else if (branch_taken) begin
      pc          <= align_pc(branch_target);
      inflight    <= 1'b0;
      instruction <= NOP_INSTR;
      pc_out      <= '0;
      valid_out   <= 1'b0;
      state       <= RUN;
    end else if (!stall) begin
      pc          <= pc + INSTR_BYTES;
      inflight    <= 1'b1;
      inflight_pc <= pc;
      state       <= RUN;
      if (hold_full) begin
        instruction <= hold_q.instr;
        pc_out      <= hold_q.pc;
        valid_out   <= 1'b1;
      end else if (inflight) begin
        instruction <= resp.instr;
        pc_out      <= resp.pc;
        valid_out   <= 1'b1;
      end else begin
        instruction <= NOP_INSTR;
        pc_out      <= '0;
        valid_out   <= 1'b0;
      end
    end else begin
      inflight <= 1'b0;
      if (inflight) state <= HELD;
    end
  end

  // No request is issued under stall, and the buffer drains on the release cycle.
  a_hold_vs_inflight: assert property (@(posedge clk) disable iff (!reset_n)
    !(hold_full && inflight));
  a_state_tracks_hold: assert property (@(posedge clk) disable iff (!reset_n)
    ((state == HELD) == hold_full));

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: address-tagged sync memory model,
// expected-PC scoreboard drained by a negedge monitor on valid & !stall.
module tb_instruction_fetch;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [63:0] pc_out;
  logic        valid_out;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   pops   = 0;

  instruction_fetch #(.RESET_PC(64'h0)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .instruction   (instruction),
    .pc_out        (pc_out),
    .valid_out     (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] tag(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h8B00_0000;
  endfunction

  // Synchronous instruction memory; junk when not requested exposes stale captures.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= tag(imem_addr);
    else          imem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_pc(input logic [63:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = tag(pc);
    sb.push_back(e);
  endtask

  // Decode consumes the IF/ID word in any cycle where it is valid and not stalled.
  always @(negedge clk) begin
    if (reset_n && valid_out && !stall) begin
      exp_t e;
      if (sb.size() == 0) begin
        chk("unexpected_output", pc_out, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", pc_out, e.pc);
        chk("sb_instr", {32'h0, instruction}, {32'h0, e.instr});
      end
      pops++;
    end else if (reset_n && !valid_out) begin
      chk("bubble_instr_zero", {32'h0, instruction}, 64'h0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1;
    stall        = 1'b0;
    branch_taken = 1'b0;
    reset_n      = 1'b1;
    #1;
    chk("first_req", {63'h0, imem_req}, 64'h1);
    chk("first_addr", imem_addr, 64'h0);
  endtask

  task automatic end_phase(input int n_exp);
    step(1);
    reset_n = 1'b0;
    #1;
    chk("sb_drained", 64'(sb.size()), 64'h0);
    chk("pop_count", 64'(pops), 64'(n_exp));
    sb.delete();
    pops = 0;
  endtask

  initial begin
    reset_n       = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    #12;
    chk("rst_valid", {63'h0, valid_out}, 64'h0);
    chk("rst_instr", {32'h0, instruction}, 64'h0);
    chk("rst_pc_out", pc_out, 64'h0);
    chk("rst_req", {63'h0, imem_req}, 64'h0);

    // Streaming with a 3-cycle stall: 0..28 contiguous.
    for (int i = 0; i < 8; i++) push_pc(64'(4 * i));
    release_reset();
    step(5);
    stall = 1'b1;
    #1;
    chk("stall_req", {63'h0, imem_req}, 64'h0);
    chk("stall_pc_out", pc_out, 64'd12);
    step(3);
    chk("frozen_pc_out", pc_out, 64'd12);
    chk("frozen_valid", {63'h0, valid_out}, 64'h1);
    stall = 1'b0;
    step(5);
    stall = 1'b1;
    end_phase(8);

    // Branch at PC 0x40 to 0x1003: 0x3C and 0x44 flushed, two bubbles.
    for (int i = 0; i < 15; i++) push_pc(64'(4 * i));
    push_pc(64'h1000);
    push_pc(64'h1004);
    release_reset();
    step(16);
    chk("br_at_addr", imem_addr, 64'h40);
    branch_taken  = 1'b1;
    branch_target = 64'h1003;
    #1;
    chk("br_no_req", {63'h0, imem_req}, 64'h0);
    step(1);
    branch_taken = 1'b0;
    #1;
    chk("br_target_addr", imem_addr, 64'h1000);
    chk("br_bubble1", {63'h0, valid_out}, 64'h0);
    step(1);
    chk("br_bubble2", {63'h0, valid_out}, 64'h0);
    step(3);
    stall = 1'b1;
    end_phase(17);

    // Branch together with stall while hold is full.
    push_pc(64'h0);
    push_pc(64'h4);
    push_pc(64'h8);
    push_pc(64'h2000);
    release_reset();
    step(5);
    stall = 1'b1;
    step(2);
    branch_taken  = 1'b1;
    branch_target = 64'h2000;
    #1;
    chk("brst_no_req", {63'h0, imem_req}, 64'h0);
    step(1);
    branch_taken = 1'b0;
    stall        = 1'b0;
    #1;
    chk("brst_valid", {63'h0, valid_out}, 64'h0);
    chk("brst_addr", imem_addr, 64'h2000);
    chk("brst_req", {63'h0, imem_req}, 64'h1);
    step(3);
    stall = 1'b1;
    end_phase(4);

    // PC wrap from the top of the address space.
    push_pc(64'hFFFF_FFFF_FFFF_FFFC);
    push_pc(64'h0);
    release_reset();
    step(1);
    branch_taken  = 1'b1;
    branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step(1);
    branch_taken = 1'b0;
    #1;
    chk("wrap_top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1);
    chk("wrap_zero_addr", imem_addr, 64'h0);
    step(3);
    stall = 1'b1;
    end_phase(2);

    // Async reset while hold is full, then restart from RESET_PC.
    push_pc(64'h0);
    push_pc(64'h4);
    push_pc(64'h8);
    push_pc(64'h0);
    release_reset();
    step(5);
    stall = 1'b1;
    step(2);
    chk("held_valid", {63'h0, valid_out}, 64'h1);
    chk("held_pc_out", pc_out, 64'd12);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", {63'h0, valid_out}, 64'h0);
    chk("arst_instr", {32'h0, instruction}, 64'h0);
    chk("arst_pc_out", pc_out, 64'h0);
    chk("arst_req", {63'h0, imem_req}, 64'h0);
    release_reset();
    step(3);
    stall = 1'b1;
    end_phase(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the LEGv8 pipeline: owns the program counter, issues requests to a synchronous instruction memory, and presents each returned 32-bit instruction with its PC in the IF/ID register to the decode stage. Decode (register file read, sign extension, control) consumes INSTRUCTION directly. The block absorbs decode stalls without losing in-flight fetches and redirects on taken branches with a flush.

## Interface
- RESET_PC, 64'h0, PC loaded on reset
- CLK  input  1  rising-edge clock, single clock domain
- RESET_N  input  1  asynchronous, active-low reset
- STALL  input  1  decode cannot accept; hold IF/ID and PC
- BRANCH_TAKEN  input  1  redirect request, single-cycle pulse
- BRANCH_TARGET  input  64  redirect PC; bits [1:0] forced to 0
- IMEM_REQ  output  1  fetch request this cycle
- IMEM_ADDR  output  64  fetch address (current PC)
- IMEM_RDATA  input  32  instruction; valid the cycle after IMEM_REQ
- INSTRUCTION  output  32  IF/ID instruction, 32'h0 when not valid
- PC_OUT  output  64  IF/ID PC of INSTRUCTION
- VALID_OUT  output  1  IF/ID holds a real instruction

## Operation
- State: PC reg; in-flight flag + in-flight PC (request issued last cycle); one-entry hold buffer (instr, PC, full); IF/ID reg (INSTRUCTION, PC_OUT, VALID_OUT).
- Reset (async, RESET_N=0): PC=RESET_PC; in-flight=0; hold empty; INSTRUCTION=0, PC_OUT=0, VALID_OUT=0; IMEM_REQ=0.
- IMEM_REQ = RESET_N & !STALL & !BRANCH_TAKEN (combinational); IMEM_ADDR = PC always.
- Request cycle: PC <= PC+4 (mod 2^64); in-flight <= 1 with PC captured; otherwise in-flight <= 0.
- Not stalled, no branch: IF/ID <= hold buffer if full (hold cleared); else in-flight response (IMEM_RDATA, in-flight PC, valid) if in-flight; else bubble (VALID_OUT=0, INSTRUCTION=0).
- Stalled, no branch: IF/ID and PC hold; if in-flight, response latched into hold buffer. Hold full and in-flight together is impossible (requests only when not stalled, and hold drains in that same cycle); assertion required.
- BRANCH_TAKEN (overrides STALL): PC <= BRANCH_TARGET & ~64'h3; in-flight response discarded; hold cleared; VALID_OUT <= 0, INSTRUCTION <= 0; no request this cycle.
- Effective FSM: RUN (hold empty), HELD (hold full, STALL high). RUN->HELD: STALL with in-flight. HELD->RUN: STALL low, or BRANCH_TAKEN. Reset -> RUN.

## Timing
- Latency: request in cycle N -> instruction visible on IF/ID outputs in cycle N+2.
- After reset release: first request at RESET_PC in first cycle; VALID_OUT high two cycles later; thereafter one instruction per cycle.
- Stall release: buffered instruction appears the cycle after release, next fetch follows back-to-back; no bubble, no duplicate, no drop.
- Taken branch in cycle N: target requested N+1, target instruction valid in N+3; two bubbles.
- Reset mid-stream: all state cleared immediately, in-flight and held data lost.

## Structure
- legv8_pkg (shared): opcode constants (LDUR, STUR, CBZ, ...), INSTR_BYTES=4, NOP_INSTR=32'h0, default RESET_PC.
- One sub-module: fetch_hold_buffer (one-entry instr/PC buffer with full flag, load/drain/clear).

## Test plan
- Reset release, RESET_PC=0, memory returns addr-tagged words -> VALID_OUT rises cycle 2 with PC_OUT 0, 4, 8, ... each cycle.
- STALL high 3 cycles during streaming -> IF/ID frozen, IMEM_REQ=0, held word emitted on release; PC_OUT sequence contiguous.
- BRANCH_TAKEN with target 0x1003 at PC 0x40 -> IMEM_ADDR 0x1000 next cycle; two VALID_OUT=0 bubbles; 0x44 never output.
- BRANCH_TAKEN and STALL same cycle while hold full -> hold cleared, redirect taken, VALID_OUT=0.
- PC=64'hFFFF_FFFF_FFFF_FFFC -> next request at 0x0.
- RESET_N low mid-stall with hold full -> outputs 0 asynchronously; restart fetches RESET_PC.
